// File: rtl/conv_im2col_addr_gen_if.sv
// Patch-address beat bus from the im2col generator to the systolic array feeder.
// The generator drives the beat and its flags; the consumer drives systolic_ready_i.
interface conv_im2col_addr_gen_if #(
  parameter int SRAM_ADDR_W = 16
) ();
  logic                   valid_o;
  logic                   systolic_ready_i;
  logic [SRAM_ADDR_W-1:0] sram_rd_addr_o;
  logic                   pad_o;
  logic                   last_patch_o;
  logic                   last_out_o;

  modport master (
    output valid_o,
    output sram_rd_addr_o,
    output pad_o,
    output last_patch_o,
    output last_out_o,
    input  systolic_ready_i
  );

  modport slave (
    input  valid_o,
    input  sram_rd_addr_o,
    input  pad_o,
    input  last_patch_o,
    input  last_out_o,
    output systolic_ready_i
  );
endinterface

// File: rtl/conv_im2col_addr_gen.sv
// Im2col read-address generator: walks oy/ox/c/ky/kx for one image per start; beat 0 one cycle after start.
// All outputs registered; a low systolic_ready_i freezes counters and every output.
module conv_im2col_addr_gen #(
  parameter int SRAM_ADDR_W = 16,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int C_IN        = 1,
  parameter int K_R         = 5,
  parameter int K_S         = 5,
  parameter int STRIDE      = 1,
  parameter int PAD         = 0,
  parameter int BASE_ADDR   = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_sync_i,
  input  logic                          start_i,
  conv_im2col_addr_gen_if.master        bus,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int OUT_W   = (IMG_W + 2*PAD - K_R) / STRIDE + 1;
  localparam int OUT_H   = (IMG_H + 2*PAD - K_S) / STRIDE + 1;
  localparam int MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW      = $clog2(MAX_DIM + 2*PAD) + 2;
  localparam int CCW     = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam int PLANE   = IMG_H * IMG_W;
  localparam int K_MIN   = (K_R < K_S) ? K_R : K_S;
  localparam longint LAST_ADDR = longint'(BASE_ADDR) + longint'(C_IN) * longint'(PLANE) - 1;

  if (C_IN < 1 || STRIDE < 1 || PAD < 0 || PAD >= K_MIN ||
      IMG_W + 2*PAD < K_R || IMG_H + 2*PAD < K_S || OUT_W < 1 || OUT_H < 1) begin : g_bad_geometry
    $error("conv_im2col_addr_gen: invalid image/kernel/stride/pad geometry");
  end
  if (LAST_ADDR >= (longint'(1) << SRAM_ADDR_W)) begin : g_bad_addr_w
    $error("conv_im2col_addr_gen: feature map does not fit in SRAM_ADDR_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef logic        [CW-1:0] cnt_t;
  typedef logic signed [CW-1:0] coord_t;

  state_t                 state, state_nxt;
  cnt_t                   oy, ox, ky, kx;
  cnt_t                   oy_n, ox_n, ky_n, kx_n;
  logic [CCW-1:0]         c, c_n;
  logic                   valid_q, valid_n;
  logic                   busy_q, busy_n;
  logic                   done_q, done_n;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_n;
  logic                   pad_q, pad_n;
  logic                   last_patch_q, last_patch_n;
  logic                   last_out_q, last_out_n;

  logic                   load_beat, clear_beat;
  coord_t                 iy, ix;
  cnt_t                   iy_u, ix_u;
  logic                   pad_calc, last_patch_calc, last_out_calc;
  logic [SRAM_ADDR_W-1:0] addr_calc;

  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      state        <= S_IDLE;
      oy           <= '0;
      ox           <= '0;
      c            <= '0;
      ky           <= '0;
      kx           <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      pad_q        <= 1'b0;
      last_patch_q <= 1'b0;
      last_out_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      oy           <= oy_n;
      ox           <= ox_n;
      c            <= c_n;
      ky           <= ky_n;
      kx           <= kx_n;
      valid_q      <= valid_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
      addr_q       <= addr_n;
      pad_q        <= pad_n;
      last_patch_q <= last_patch_n;
      last_out_q   <= last_out_n;
    end
  end

  always_comb begin
    state_nxt  = state;
    oy_n       = oy;
    ox_n       = ox;
    c_n        = c;
    ky_n       = ky;
    kx_n       = kx;
    valid_n    = valid_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
    load_beat  = 1'b0;
    clear_beat = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_RUN;
          oy_n      = '0;
          ox_n      = '0;
          c_n       = '0;
          ky_n      = '0;
          kx_n      = '0;
          valid_n   = 1'b1;
          busy_n    = 1'b1;
          load_beat = 1'b1;
        end
      end
      S_RUN: begin
        if (valid_q && bus.systolic_ready_i) begin
          if (last_out_q) begin
            state_nxt  = S_DONE;
            valid_n    = 1'b0;
            busy_n     = 1'b0;
            done_n     = 1'b1;
            clear_beat = 1'b1;
          end else begin
            load_beat = 1'b1;
            // Ripple-carry through the loop nest, kx innermost.
            if (kx == cnt_t'(K_R - 1)) begin
              kx_n = '0;
              if (ky == cnt_t'(K_S - 1)) begin
                ky_n = '0;
                if (c == CCW'(C_IN - 1)) begin
                  c_n = '0;
                  if (ox == cnt_t'(OUT_W - 1)) begin
                    ox_n = '0;
                    oy_n = oy + cnt_t'(1);
                  end else begin
                    ox_n = ox + cnt_t'(1);
                  end
                end else begin
                  c_n = c + CCW'(1);
                end
              end else begin
                ky_n = ky + cnt_t'(1);
              end
            end else begin
              kx_n = kx + cnt_t'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Beat fields come from the next counter state so the register holds the beat being presented.
    iy   = coord_t'(oy_n) * coord_t'(STRIDE) + coord_t'(ky_n) - coord_t'(PAD);
    ix   = coord_t'(ox_n) * coord_t'(STRIDE) + coord_t'(kx_n) - coord_t'(PAD);
    iy_u = iy;
    ix_u = ix;
    pad_calc = iy[CW-1] || (iy >= coord_t'(IMG_H)) || ix[CW-1] || (ix >= coord_t'(IMG_W));
    last_patch_calc = (c_n == CCW'(C_IN - 1)) && (ky_n == cnt_t'(K_S - 1)) && (kx_n == cnt_t'(K_R - 1));
    last_out_calc   = last_patch_calc && (oy_n == cnt_t'(OUT_H - 1)) && (ox_n == cnt_t'(OUT_W - 1));
    addr_calc = pad_calc ? '0 :
                SRAM_ADDR_W'(32'(BASE_ADDR) + 32'(c_n) * 32'(PLANE) +
                              32'(iy_u) * 32'(IMG_W) + 32'(ix_u));

    addr_n       = addr_q;
    pad_n        = pad_q;
    last_patch_n = last_patch_q;
    last_out_n   = last_out_q;
    if (load_beat) begin
      addr_n       = addr_calc;
      pad_n        = pad_calc;
      last_patch_n = last_patch_calc;
      last_out_n   = last_out_calc;
    end else if (clear_beat) begin
      addr_n       = '0;
      pad_n        = 1'b0;
      last_patch_n = 1'b0;
      last_out_n   = 1'b0;
    end
  end

  assign bus.valid_o        = valid_q;
  assign bus.sram_rd_addr_o = addr_q;
  assign bus.pad_o          = pad_q;
  assign bus.last_patch_o   = last_patch_q;
  assign bus.last_out_o     = last_out_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_conv_im2col_addr_gen.sv
// Bench for conv_im2col_addr_gen: three geometries checked against a nested-loop reference of the
// im2col patch walk, with random back-pressure, stray start pulses and a mid-image reset.
module tb_conv_im2col_addr_gen;
  localparam int AW = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic        pad;
    logic        lp;
    logic        lo;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_s [3];
  logic          rdy_s   [3];
  logic          vld_s   [3];
  logic          pad_s   [3];
  logic          lp_s    [3];
  logic          lo_s    [3];
  logic          busy_s  [3];
  logic          done_s  [3];
  logic [AW-1:0] addr_s  [3];

  conv_im2col_addr_gen_if #(.SRAM_ADDR_W(AW)) bus0 ();
  conv_im2col_addr_gen_if #(.SRAM_ADDR_W(AW)) bus1 ();
  conv_im2col_addr_gen_if #(.SRAM_ADDR_W(AW)) bus2 ();

  assign bus0.systolic_ready_i = rdy_s[0];
  assign bus1.systolic_ready_i = rdy_s[1];
  assign bus2.systolic_ready_i = rdy_s[2];
  assign vld_s[0] = bus0.valid_o;  assign addr_s[0] = bus0.sram_rd_addr_o;
  assign pad_s[0] = bus0.pad_o;    assign lp_s[0] = bus0.last_patch_o;  assign lo_s[0] = bus0.last_out_o;
  assign vld_s[1] = bus1.valid_o;  assign addr_s[1] = bus1.sram_rd_addr_o;
  assign pad_s[1] = bus1.pad_o;    assign lp_s[1] = bus1.last_patch_o;  assign lo_s[1] = bus1.last_out_o;
  assign vld_s[2] = bus2.valid_o;  assign addr_s[2] = bus2.sram_rd_addr_o;
  assign pad_s[2] = bus2.pad_o;    assign lp_s[2] = bus2.last_patch_o;  assign lo_s[2] = bus2.last_out_o;

  conv_im2col_addr_gen u_dut0 (
    .clk_i(clk), .rst_sync_i(rst), .start_i(start_s[0]), .bus(bus0),
    .busy_o(busy_s[0]), .done_o(done_s[0]));

  conv_im2col_addr_gen #(.IMG_W(4), .IMG_H(4), .C_IN(1), .K_R(3), .K_S(3), .STRIDE(2), .PAD(1)) u_dut1 (
    .clk_i(clk), .rst_sync_i(rst), .start_i(start_s[1]), .bus(bus1),
    .busy_o(busy_s[1]), .done_o(done_s[1]));

  conv_im2col_addr_gen #(.IMG_W(4), .IMG_H(4), .C_IN(2), .K_R(2), .K_S(2), .STRIDE(1), .PAD(0)) u_dut2 (
    .clk_i(clk), .rst_sync_i(rst), .start_i(start_s[2]), .bus(bus2),
    .busy_o(busy_s[2]), .done_o(done_s[2]));

  // Geometry of each instance: iw, ih, c_in, k_r, k_s, stride, pad
  int cfg [3][7] = '{'{28, 28, 1, 5, 5, 1, 0}, '{4, 4, 1, 3, 3, 2, 1}, '{4, 4, 2, 2, 2, 1, 0}};

  beat_t exp_q [$];
  beat_t obs_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int r_mism, r_first_bad, r_acc, r_stall_err, r_done, r_run_err, r_end_err;
  logic [31:0] r_bad_got, r_bad_exp;
  bit r_lat_ok;

  task automatic build_model(input int k);
    int iw, ih, ci, kr, ks, st, pd, ow, oh, iy, ix;
    beat_t b;
    iw = cfg[k][0]; ih = cfg[k][1]; ci = cfg[k][2]; kr = cfg[k][3];
    ks = cfg[k][4]; st = cfg[k][5]; pd = cfg[k][6];
    ow = (iw + 2*pd - kr) / st + 1;
    oh = (ih + 2*pd - ks) / st + 1;
    exp_q.delete();
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int c = 0; c < ci; c++)
          for (int ky = 0; ky < ks; ky++)
            for (int kx = 0; kx < kr; kx++) begin
              iy = oy*st + ky - pd;
              ix = ox*st + kx - pd;
              b.pad  = (iy < 0) || (iy >= ih) || (ix < 0) || (ix >= iw);
              b.addr = b.pad ? 32'd0 : 32'(c*ih*iw + iy*iw + ix);
              b.lp   = (c == ci-1) && (ky == ks-1) && (kx == kr-1);
              b.lo   = b.lp && (oy == oh-1) && (ox == ow-1);
              exp_q.push_back(b);
            end
  endtask

  // Drives one image through instance k; stops early once stop_at beats are accepted.
  task automatic run_image(input int k, input bit bp, input bit spulse, input int stop_at);
    int total, budget, cyc;
    beat_t cur, prev;
    bit prev_stall;
    total = exp_q.size(); budget = total*4 + 200; cyc = 0;
    prev = '0; prev_stall = 1'b0;
    r_mism = 0; r_first_bad = -1; r_bad_got = '0; r_bad_exp = '0; r_acc = 0;
    r_stall_err = 0; r_done = 0; r_run_err = 0; r_end_err = 0;
    obs_q.delete();
    @(negedge clk);
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    r_lat_ok = (vld_s[k] === 1'b1);
    while (r_acc < stop_at && r_acc < total && cyc < budget) begin
      cur = '{addr: 32'(addr_s[k]), pad: pad_s[k], lp: lp_s[k], lo: lo_s[k]};
      if (vld_s[k] !== 1'b1 || busy_s[k] !== 1'b1) r_run_err++;
      if (done_s[k] === 1'b1) r_done++;
      if (prev_stall && cur !== prev) r_stall_err++;
      rdy_s[k]   = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      start_s[k] = spulse && ($urandom_range(0, 15) == 0);
      if (rdy_s[k] === 1'b1 && vld_s[k] === 1'b1) begin
        if (cur !== exp_q[r_acc]) begin
          if (r_mism == 0) begin
            r_first_bad = r_acc; r_bad_got = cur.addr; r_bad_exp = exp_q[r_acc].addr;
          end
          r_mism++;
        end
        obs_q.push_back(cur);
        r_acc++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
      end
      prev = cur;
      @(negedge clk);
      cyc++;
    end
    start_s[k] = 1'b0;
    if (r_acc >= total) begin
      for (int i = 0; i < 4; i++) begin
        rdy_s[k] = ($urandom_range(0, 1) == 1);
        if (vld_s[k] !== 1'b0 || busy_s[k] !== 1'b0 || lo_s[k] !== 1'b0) r_end_err++;
        if (done_s[k] === 1'b1) r_done++;
        @(negedge clk);
      end
    end
    rdy_s[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({vld_s[k], pad_s[k], lp_s[k], lo_s[k], busy_s[k], done_s[k]} !== 6'b0 || addr_s[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got v%b p%b lp%b lo%b b%b d%b a%0d, required all 0",
                 k, vld_s[k], pad_s[k], lp_s[k], lo_s[k], busy_s[k], done_s[k], addr_s[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_ready();
    int hits;
    hits = 0;
    for (int k = 0; k < 3; k++) rdy_s[k] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (vld_s[k] !== 1'b0 || done_s[k] !== 1'b0 || busy_s[k] !== 1'b0) hits++;
    end
    for (int k = 0; k < 3; k++) rdy_s[k] = 1'b0;
    n_tests++;
    if (hits !== 0) begin
      n_fail++;
      $display("FAIL idle_ready: %0d cycles with valid/busy/done set, required 0", hits);
    end
  endtask

  task automatic test_default();
    int t25 [25];
    int bad, pads, lps;
    t25 = '{0,1,2,3,4, 28,29,30,31,32, 56,57,58,59,60, 84,85,86,87,88, 112,113,114,115,116};
    build_model(0);
    run_image(0, 1'b0, 1'b0, 1 << 30);
    n_tests++;
    if (!r_lat_ok) begin n_fail++; $display("FAIL default_latency: valid not 1 one cycle after start, required 1"); end
    n_tests++;
    if (r_mism !== 0) begin
      n_fail++;
      $display("FAIL default_stream: %0d bad beats, first #%0d addr %0d required %0d", r_mism, r_first_bad, r_bad_got, r_bad_exp);
    end
    n_tests++;
    if (r_acc !== 14400) begin n_fail++; $display("FAIL default_count: got %0d beats, required 14400", r_acc); end
    bad = 0; pads = 0; lps = 0;
    for (int i = 0; i < 25; i++) if (i >= obs_q.size() || obs_q[i].addr !== 32'(t25[i])) bad++;
    for (int i = 0; i < 24 && i < obs_q.size(); i++) if (obs_q[i].lp) lps++;
    foreach (obs_q[i]) if (obs_q[i].pad) pads++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL default_first25: %0d wrong addresses, required 0", bad); end
    n_tests++;
    if (obs_q.size() < 25 || obs_q[24].lp !== 1'b1 || lps !== 0) begin
      n_fail++; $display("FAIL default_last_patch: early lp %0d / beat24 lp missing, required only beat 24", lps);
    end
    n_tests++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1].addr !== 32'd783 || obs_q[obs_q.size()-1].lo !== 1'b1) begin
      n_fail++; $display("FAIL default_final_beat: final beat wrong or missing, required addr 783 with last_out");
    end
    n_tests++;
    if (pads !== 0) begin n_fail++; $display("FAIL default_pad: got %0d pad beats, required 0", pads); end
    n_tests++;
    if (r_done !== 1 || r_end_err !== 0 || r_run_err !== 0) begin
      n_fail++; $display("FAIL default_framing: done %0d end_err %0d run_err %0d, required 1/0/0", r_done, r_end_err, r_run_err);
    end
  endtask

  task automatic test_pad_stride();
    int pp [9];
    int a3 [9];
    int nonpad [4];
    int bad, np;
    pp = '{1,1,1,1,0,0,1,0,0};
    a3 = '{5,6,7,9,10,11,13,14,15};
    nonpad = '{0,1,4,5};
    build_model(1);
    run_image(1, 1'b0, 1'b0, 1 << 30);
    n_tests++;
    if (r_mism !== 0 || r_acc !== 36) begin
      n_fail++; $display("FAIL pad_stream: %0d bad beats, %0d beats, required 0 bad and 36 beats", r_mism, r_acc);
    end
    bad = 0; np = 0;
    for (int i = 0; i < 9; i++) begin
      if (i >= obs_q.size()) bad++;
      else begin
        if (obs_q[i].pad !== pp[i][0]) bad++;
        if (!obs_q[i].pad) begin
          if (np > 3 || obs_q[i].addr !== 32'(nonpad[np])) bad++;
          np++;
        end else if (obs_q[i].addr !== 32'd0) bad++;
      end
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL pad_patch0: %0d wrong pad/addr beats, required 0", bad); end
    bad = 0;
    for (int i = 0; i < 9; i++)
      if (27 + i >= obs_q.size() || obs_q[27+i].pad !== 1'b0 || obs_q[27+i].addr !== 32'(a3[i])) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL pad_patch3: %0d wrong beats, required 0", bad); end
    n_tests++;
    if (r_done !== 1 || r_end_err !== 0) begin
      n_fail++; $display("FAIL pad_done: done %0d end_err %0d, required 1/0", r_done, r_end_err);
    end
  endtask

  task automatic test_multichan();
    int a0 [8];
    int bad;
    a0 = '{0,1,4,5,16,17,20,21};
    build_model(2);
    run_image(2, 1'b0, 1'b0, 1 << 30);
    n_tests++;
    if (r_mism !== 0 || r_acc !== 72) begin
      n_fail++; $display("FAIL chan_stream: %0d bad beats, %0d beats, required 0 bad and 72 beats", r_mism, r_acc);
    end
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (i >= obs_q.size() || obs_q[i].addr !== 32'(a0[i]) || obs_q[i].lp !== (i == 7)) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL chan_patch0: %0d wrong beats, required 0", bad); end
  endtask

  task automatic test_backpressure();
    build_model(0);
    run_image(0, 1'b1, 1'b0, 1 << 30);
    n_tests++;
    if (r_mism !== 0) begin
      n_fail++;
      $display("FAIL bp_stream: %0d bad beats, first #%0d addr %0d required %0d", r_mism, r_first_bad, r_bad_got, r_bad_exp);
    end
    n_tests++;
    if (r_stall_err !== 0) begin n_fail++; $display("FAIL bp_hold: %0d stalled cycles changed outputs, required 0", r_stall_err); end
    n_tests++;
    if (r_acc !== 14400 || r_done !== 1) begin
      n_fail++; $display("FAIL bp_count: %0d beats, done %0d, required 14400 and 1", r_acc, r_done);
    end
  endtask

  task automatic test_reset_mid();
    build_model(0);
    run_image(0, 1'b0, 1'b0, 100);
    n_tests++;
    if (r_acc !== 100 || r_mism !== 0) begin
      n_fail++; $display("FAIL rst_prefix: %0d beats, %0d bad, required 100 and 0", r_acc, r_mism);
    end
    rst = 1'b1;
    rdy_s[0] = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({vld_s[0], pad_s[0], lp_s[0], lo_s[0], busy_s[0], done_s[0]} !== 6'b0 || addr_s[0] !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got v%b b%b a%0d, required all 0", vld_s[0], busy_s[0], addr_s[0]);
    end
    rst = 1'b0;
    rdy_s[0] = 1'b0;
    run_image(0, 1'b0, 1'b1, 1 << 30);
    n_tests++;
    if (obs_q.size() == 0 || obs_q[0].addr !== 32'd0) begin
      n_fail++; $display("FAIL rst_restart_addr: first beat wrong or missing, required addr 0");
    end
    n_tests++;
    if (r_mism !== 0 || r_acc !== 14400 || r_done !== 1) begin
      n_fail++; $display("FAIL rst_start_pulses: %0d bad, %0d beats, done %0d, required 0/14400/1", r_mism, r_acc, r_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin start_s[k] = 1'b0; rdy_s[k] = 1'b0; end
    test_reset();
    test_idle_ready();
    test_default();
    test_pad_stride();
    test_multichan();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
